// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register for an in-order 5-stage pipeline.
//               Detects load-use hazards against the instruction already in
//               EX and raises a combinational stall so that IF/ID holds while
//               a bubble is written into EX. The register update follows a
//               strict priority on each rising clock edge:
//               hold > flush > load-use bubble > normal load.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN            datapath width (default 32)
// Optional build macro
//   STALL_COUNT_EN  adds the 32-bit saturating output stall_count, which
//                   counts the load-use bubbles that have been written.
// Ports
//   clk             in   1     rising-edge clock
//   rst_n           in   1     asynchronous active-low reset
//   id_valid        in   1     ID holds a real instruction
//   id_pc           in   XLEN  PC of the ID instruction
//   id_rs1/rs2/rd   in   5     register indices
//   id_uses_rs1/2   in   1     instruction actually reads that source
//   id_rs1_data     in   XLEN  source operand 1
//   id_rs2_data     in   XLEN  source operand 2
//   id_imm          in   XLEN  immediate
//   id_ctrl         in   8     {alu_op[2:0], alu_src, mem_to_reg,
//                               mem_write, mem_read, reg_write}
//   ex_flush        in   1     taken branch/jump resolved in EX
//   ex_hold         in   1     downstream freeze (memory wait)
//   stall           out  1     combinational; hold PC and IF/ID this cycle
//   id_ex_valid     out  1     EX slot holds a real instruction
//   id_ex_*         out  -     registered copies of the ID fields
//   stall_count     out  32    load-use bubbles written (STALL_COUNT_EN only)
// ============================================================================
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [7:0]      id_ctrl,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            stall,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [7:0]      id_ex_ctrl
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  // Position of the mem_read flag inside the control bundle.
  localparam int C_MEM_READ_BIT = 1;

  // --------------------------------------------------------------------------
  // Pipeline register contents
  // --------------------------------------------------------------------------
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [7:0]      r_ctrl;

  // --------------------------------------------------------------------------
  // Load-use hazard detection
  // --------------------------------------------------------------------------
  logic w_ex_is_load;
  logic w_rs1_dep;
  logic w_rs2_dep;
  logic w_load_use;
  logic w_do_bubble;
  logic w_lu_bubble;

  // A load targeting x0 never produces a value anyone waits for.
  assign w_ex_is_load = r_valid && r_ctrl[C_MEM_READ_BIT] && (r_rd != 5'd0);
  assign w_rs1_dep    = id_uses_rs1 && (id_rs1 == r_rd);
  assign w_rs2_dep    = id_uses_rs2 && (id_rs2 == r_rd);
  assign w_load_use   = id_valid && w_ex_is_load && (w_rs1_dep || w_rs2_dep);

  // A flush already kills the dependent ID instruction, so it needs no stall.
  assign stall = ex_hold || (w_load_use && !ex_flush);

  // Edge action selection (hold is handled first in the register block).
  assign w_do_bubble = ex_flush || w_load_use;
  assign w_lu_bubble = !ex_hold && !ex_flush && w_load_use;

  // --------------------------------------------------------------------------
  // ID/EX register update: hold > flush > load-use > load
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_ctrl     <= 8'd0;
    end else if (ex_hold) begin
      // Frozen: every field keeps its value. A pending flush is held stable
      // by the frozen EX instruction and is applied once the hold drops.
      r_valid    <= r_valid;
      r_pc       <= r_pc;
      r_rs1_data <= r_rs1_data;
      r_rs2_data <= r_rs2_data;
      r_imm      <= r_imm;
      r_rs1      <= r_rs1;
      r_rs2      <= r_rs2;
      r_rd       <= r_rd;
      r_ctrl     <= r_ctrl;
    end else if (w_do_bubble) begin
      // Bubble: fully zeroed slot so no stale index can match forwarding.
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_ctrl     <= 8'd0;
    end else begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      // An invalid slot must never carry side-effecting control.
      r_ctrl     <= id_valid ? id_ctrl : 8'd0;
    end
  end

  assign id_ex_valid    = r_valid;
  assign id_ex_pc       = r_pc;
  assign id_ex_rs1_data = r_rs1_data;
  assign id_ex_rs2_data = r_rs2_data;
  assign id_ex_imm      = r_imm;
  assign id_ex_rs1      = r_rs1;
  assign id_ex_rs2      = r_rs2;
  assign id_ex_rd       = r_rd;
  assign id_ex_ctrl     = r_ctrl;

  // --------------------------------------------------------------------------
  // Optional saturating load-use bubble counter
  // --------------------------------------------------------------------------
`ifdef STALL_COUNT_EN
  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 32'd0;
    end else if (w_lu_bubble && (r_stall_count != C_CNT_MAX)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  // Keeps the bubble-select term referenced in the counter-less build.
  logic w_unused;
  assign w_unused = w_lu_bubble;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A behavioural model of
//               the EX slot predicts stall and the registered outputs from
//               the hazard and priority rules; directed scenarios are
//               followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int VW   = 1 + 4 * XLEN + 15 + 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid = 1'b0;
  logic [XLEN-1:0] id_pc = '0;
  logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic            id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic [XLEN-1:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [7:0]      id_ctrl = '0;
  logic            ex_flush = 1'b0, ex_hold = 1'b0;
  logic            stall, id_ex_valid;
  logic [XLEN-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]      id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [7:0]      id_ex_ctrl;
`ifdef STALL_COUNT_EN
  logic [31:0]     stall_count;
`endif

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_flush(ex_flush), .ex_hold(ex_hold),
    .stall(stall), .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_ctrl(id_ex_ctrl)
`ifdef STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Observed outputs as one vector: {valid, pc, rs1d, rs2d, imm, rs1, rs2, rd, ctrl}
  logic [VW-1:0] dut_vec;
  assign dut_vec = {id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
                    id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_ctrl};

  // Reference model: contents of the EX slot plus the bubble count.
  logic [VW-1:0] m_slot = '0;
  logic [31:0]   m_cnt  = 32'd0;

  function automatic logic [4:0] m_rd();
    return m_slot[12:8];
  endfunction

  function automatic logic m_lu();
    logic ex_load;
    ex_load = m_slot[VW-1] && m_slot[1] && (m_rd() != 5'd0);
    return id_valid && ex_load &&
           ((id_uses_rs1 && id_rs1 == m_rd()) || (id_uses_rs2 && id_rs2 == m_rd()));
  endfunction

  function automatic logic exp_stall();
    return ex_hold || (m_lu() && !ex_flush);
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (!rst_n) begin
      m_slot = '0;
      m_cnt  = 32'd0;
    end else if (ex_hold) begin
      m_slot = m_slot;
    end else if (ex_flush) begin
      m_slot = '0;
    end else if (m_lu()) begin
      m_slot = '0;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_slot = {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
                id_rs1, id_rs2, id_rd, (id_valid ? id_ctrl : 8'd0)};
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic [7:0] ctrl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = ctrl;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; ex_hold = 1'b0; ex_flush = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'hFF);
    m_slot = '0; m_cnt = 32'd0;
    #2;
    n_cmp++;
    if (dut_vec !== m_slot) begin
      n_err++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, m_slot);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall_idle: got %b expected 0", stall);
    end
    ex_hold = 1'b1; #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL reset_stall_hold: got %b expected 1", stall);
    end
    ex_hold = 1'b0;
    cycle(); cycle();
    n_cmp++;
    if (dut_vec !== m_slot) begin
      n_err++; $display("FAIL reset_clocked: got %h expected %h", dut_vec, m_slot);
    end
`ifdef STALL_COUNT_EN
    n_cmp++;
    if (stall_count !== 32'd0) begin
      n_err++; $display("FAIL reset_count: got %0d expected 0", stall_count);
    end
`endif
    rst_n = 1'b1;
    #1;
  endtask

  // lw x5 in EX, then add reading x5: one bubble, then add enters EX.
  task automatic test_load_use();
    logic [31:0] cnt0;
    ex_hold = 1'b0; ex_flush = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 8'h0B);
    cycle();
    cnt0 = m_cnt;
    set_id(1'b1, 5'd5, 5'd4, 5'd6, 1'b1, 1'b1, 8'h01);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL lu_stall: got %b expected 1", stall);
    end
    cycle();
    n_cmp++;
    if (dut_vec !== m_slot || id_ex_valid !== 1'b0 || id_ex_ctrl !== 8'd0) begin
      n_err++; $display("FAIL lu_bubble: got %h expected %h", dut_vec, m_slot);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL lu_stall_release: got %b expected 0", stall);
    end
    cycle();
    n_cmp++;
    if (dut_vec !== m_slot || id_ex_valid !== 1'b1 || id_ex_rd !== 5'd6) begin
      n_err++; $display("FAIL lu_add_enters: got %h expected %h", dut_vec, m_slot);
    end
`ifdef STALL_COUNT_EN
    n_cmp++;
    if (stall_count !== cnt0 + 32'd1) begin
      n_err++; $display("FAIL lu_count: got %0d expected %0d", stall_count, cnt0 + 1);
    end
`else
    cnt0 = cnt0;
`endif
  endtask

  // Load into x0 never stalls.
  task automatic test_x0();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 8'h0B);
    cycle();
    set_id(1'b1, 5'd0, 5'd3, 5'd8, 1'b1, 1'b1, 8'h01);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL x0_stall: got %b expected 0", stall);
    end
    cycle();
    n_cmp++;
    if (dut_vec !== m_slot || id_ex_valid !== 1'b1 || id_ex_rd !== 5'd8) begin
      n_err++; $display("FAIL x0_capture: got %h expected %h", dut_vec, m_slot);
    end
  endtask

  // Matching index on a source the instruction does not read.
  task automatic test_unused_src();
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 8'h0B);
    cycle();
    set_id(1'b1, 5'd3, 5'd7, 5'd9, 1'b1, 1'b0, 8'h11);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL unused_stall: got %b expected 0", stall);
    end
    cycle();
    n_cmp++;
    if (dut_vec !== m_slot || id_ex_valid !== 1'b1) begin
      n_err++; $display("FAIL unused_capture: got %h expected %h", dut_vec, m_slot);
    end
  endtask

  // Invalid ID instruction carries no control into EX.
  task automatic test_invalid_load();
    set_id(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'hFF);
    cycle();
    n_cmp++;
    if (dut_vec !== m_slot || id_ex_ctrl !== 8'd0 || id_ex_rd !== 5'd3) begin
      n_err++; $display("FAIL invalid_load: got %h expected %h", dut_vec, m_slot);
    end
  endtask

  // Flush and load-use in the same cycle.
  task automatic test_flush_vs_lu();
    logic [31:0] cnt0;
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 8'h0B);
    cycle();
    cnt0 = m_cnt;
    set_id(1'b1, 5'd9, 5'd2, 5'd4, 1'b1, 1'b0, 8'h01);
    ex_flush = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL flush_lu_stall: got %b expected 0", stall);
    end
    cycle();
    n_cmp++;
    if (dut_vec !== m_slot || id_ex_valid !== 1'b0 || id_ex_ctrl !== 8'd0) begin
      n_err++; $display("FAIL flush_lu_bubble: got %h expected %h", dut_vec, m_slot);
    end
`ifdef STALL_COUNT_EN
    n_cmp++;
    if (stall_count !== cnt0) begin
      n_err++; $display("FAIL flush_lu_count: got %0d expected %0d", stall_count, cnt0);
    end
`else
    cnt0 = cnt0;
`endif
    ex_flush = 1'b0;
  endtask

  // Hold for three cycles with a pending flush, then the flush lands.
  task automatic test_hold_flush();
    logic [VW-1:0] snap;
    set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 8'h1D);
    cycle();
    snap = dut_vec;
    ex_hold = 1'b1; ex_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 8'($urandom));
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
        n_err++; $display("FAIL hold_stall[%0d]: got %b expected 1", i, stall);
      end
      cycle();
      n_cmp++;
      if (dut_vec !== snap || dut_vec !== m_slot) begin
        n_err++; $display("FAIL hold_frozen[%0d]: got %h expected %h", i, dut_vec, snap);
      end
    end
    ex_hold = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL hold_release_stall: got %b expected 0", stall);
    end
    cycle();
    n_cmp++;
    if (dut_vec !== {VW{1'b0}} || m_slot !== {VW{1'b0}}) begin
      n_err++; $display("FAIL hold_flush_bubble: got %h expected 0", dut_vec);
    end
    ex_flush = 1'b0;
  endtask

  // Reset asserted between edges, while a hold freezes a valid instruction.
  task automatic test_async_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd14, 1'b1, 1'b0, 8'h03);
    cycle();
    n_cmp++;
    if (id_ex_valid !== 1'b1 || id_ex_ctrl !== 8'h03) begin
      n_err++; $display("FAIL async_preload: got valid=%b ctrl=%h expected 1/03",
                        id_ex_valid, id_ex_ctrl);
    end
    ex_hold = 1'b1;
    #3;
    rst_n = 1'b0;
    m_slot = '0; m_cnt = 32'd0;
    #1;
    n_cmp++;
    if (dut_vec !== {VW{1'b0}}) begin
      n_err++; $display("FAIL async_clear: got %h expected 0", dut_vec);
    end
`ifdef STALL_COUNT_EN
    n_cmp++;
    if (stall_count !== 32'd0) begin
      n_err++; $display("FAIL async_count: got %0d expected 0", stall_count);
    end
`endif
    @(posedge clk); #1;
    ex_hold = 1'b0;
    #2;
    rst_n = 1'b1;
    set_id(1'b1, 5'd3, 5'd4, 5'd15, 1'b1, 1'b1, 8'h21);
    cycle();
    n_cmp++;
    if (dut_vec !== m_slot || id_ex_valid !== 1'b1) begin
      n_err++; $display("FAIL async_first_edge: got %h expected %h", dut_vec, m_slot);
    end
  endtask

  // Randomized run, small register range to make hazards frequent.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 1) == 1) ? (8'($urandom) | 8'h02) : 8'($urandom));
      ex_hold  = ($urandom_range(0, 9) < 2);
      ex_flush = ($urandom_range(0, 9) < 2);
      #1;
      n_cmp++;
      if (stall !== exp_stall()) begin
        n_err++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, stall, exp_stall());
      end
      cycle();
      n_cmp++;
      if (dut_vec !== m_slot) begin
        n_err++; $display("FAIL rand_regs[%0d]: got %h expected %h", i, dut_vec, m_slot);
      end
`ifdef STALL_COUNT_EN
      n_cmp++;
      if (stall_count !== m_cnt) begin
        n_err++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, stall_count, m_cnt);
      end
`endif
    end
    ex_hold = 1'b0; ex_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_unused_src();
    test_invalid_load();
    test_flush_vs_lu();
    test_hold_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, datapath width.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, named clk and rst_n; the ports SHALL be the following.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads that source.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands and immediate.
- id_ctrl  in  8  control bundle: bit0 reg_write, bit1 mem_read, bit2 mem_write, bit3 mem_to_reg, bit4 alu_src, bits7:5 alu_op.
- ex_flush  in  1  taken branch/jump resolved in EX.
- ex_hold  in  1  downstream freeze (memory wait).
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- id_ex_valid  out  1  EX slot holds a real instruction.
- id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  out  XLEN each  registered copies.
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  registered indices, consumed by forwarding.
- id_ex_ctrl  out  8  registered control bundle.

Function
REQ-003 Load-use hazard (lu) SHALL be: id_valid, id_ex_valid, id_ex_ctrl[1], id_ex_rd != 0, and ((id_uses_rs1 and id_rs1 == id_ex_rd) or (id_uses_rs2 and id_rs2 == id_ex_rd)).
REQ-004 stall SHALL equal ex_hold or (lu and not ex_flush).
REQ-005 Each rising clk SHALL update the register by strict priority: hold > flush > lu > load.
REQ-006 Hold: ex_hold = 1 SHALL keep every id_ex_* output unchanged.
REQ-007 Flush: ex_flush = 1 with ex_hold = 0 SHALL write a bubble.
REQ-008 Bubble definition: id_ex_valid = 0 and id_ex_ctrl = 0. Other id_ex_* fields are don't-care; the implementation SHALL write 0.
REQ-009 Flush during hold: the flush SHALL take effect on the first edge where ex_hold = 0. ex_flush is held stable by the frozen EX instruction.
REQ-010 lu = 1 with ex_hold = 0 and ex_flush = 0 SHALL write a bubble. The ID instruction then remains at the ID inputs for the next cycle.
REQ-011 Load: all id_* inputs SHALL be captured into the id_ex_* outputs, with id_ex_valid = id_valid.
REQ-012 Load with id_valid = 0 SHALL force id_ex_ctrl = 0, so no side-effecting control ever leaves an invalid slot.
REQ-013 Latency SHALL be one cycle from ID inputs to id_ex_* outputs.
REQ-014 A single load-use case SHALL cost exactly one bubble. After the bubble, id_ex_ctrl[1] = 0, so lu deasserts.
REQ-015 id_ex_rd = 0 SHALL never cause lu, even when id_ex_ctrl[1] = 1.

Reset
REQ-016 rst_n low SHALL immediately, without waiting for clk, set id_ex_valid = 0 and id_ex_ctrl = 0.
REQ-017 rst_n low SHALL immediately clear all other id_ex_* outputs to 0.
REQ-018 During reset, stall SHALL follow REQ-004 from the reset register values; ex_hold can still assert it.
REQ-019 Reset asserted mid-stall or mid-hold SHALL discard the held instruction.
REQ-020 After release, the first rising clk SHALL perform a normal priority update.

Configuration
REQ-021 Macro STALL_COUNT_EN SHALL add output port stall_count (32 bits).
REQ-022 With STALL_COUNT_EN, stall_count SHALL increment on every edge where a load-use bubble is written (REQ-010).
REQ-023 stall_count SHALL saturate at 0xFFFFFFFF and reset to 0 with rst_n.
REQ-024 Without STALL_COUNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-025 Load then dependent use: lw x5 in EX (ctrl[1]=1, rd=5), ID add reading rs1=5 -> stall=1 for one cycle, one bubble written, add enters EX next cycle, stall_count=1.
REQ-026 Load to x0: EX rd=0 with mem_read=1, ID rs1=0 -> stall=0, ID instruction captured normally.
REQ-027 Unused source: EX lw rd=7, ID rs2=7 with id_uses_rs2=0 -> stall=0, no bubble.
REQ-028 Flush vs load-use: lu=1 and ex_flush=1 in the same cycle -> stall=0, bubble written, stall_count unchanged.
REQ-029 Hold with pending flush: ex_hold=1 for 3 cycles with ex_flush=1 -> outputs frozen 3 cycles and stall=1, then a bubble on the first edge after ex_hold=0.
REQ-030 Async reset mid-operation: rst_n low between edges while id_ex_valid=1, ctrl=0x03 -> outputs 0 before the next edge, stall_count=0.
